vga_board_renderer: RTL and testbench
=====================================

// Module: vga_board_renderer
// PURPOSE
//  Pixel stage directly downstream of the VGA timing controller. Consumes H/V counts, blank and syncs; outputs 24-bit RGB.
//  Draws a COLSxROWS game board of circular cells from an internal cell-state register file, written by game logic.
//  Adds a blinking cursor piece above the selected column. 2-cycle pipeline; syncs/blank are delayed to stay aligned.
// PARAMETERS
//  COLS        7    board columns (1..8)
//  ROWS        6    board rows (1..8)
//  CELL_LOG2   6    cell edge = 2**CELL_LOG2 px (64)
//  X0          96   board left edge, px
//  Y0          64   board top edge, px; cursor band is rows Y0-CELL..Y0-1
//  RADIUS_SQ   676  piece radius squared (r=26)
//  BLINK_FRAMES 30  frames per cursor blink half-period
// PORTS
//  clk          in   1   pixel clock, same clock as timing controller
//  rst_n        in   1   asynchronous active-low reset
//  h_count      in   16  horizontal pixel count
//  v_count      in   16  vertical line count
//  blank_in     in   1   1 = visible pixel (controller convention)
//  hsync_in     in   1   controller hsync, active low
//  vsync_in     in   1   controller vsync, active low
//  wr_en        in   1   write one cell this cycle
//  wr_col       in   3   column to write
//  wr_row       in   3   row to write (0 = top)
//  wr_data      in   2   0 empty, 1 player1, 2 player2, 3 highlight
//  clear        in   1   set all cells to empty
//  cursor_col   in   3   column of cursor piece
//  cursor_player in  1   0 = player1 colour, 1 = player2 colour
//  red/green/blue out 8 each  pixel colour
//  hsync_out    out  1   hsync_in delayed 2 cycles
//  vsync_out    out  1   vsync_in delayed 2 cycles
//  blank_out    out  1   blank_in delayed 2 cycles
// BEHAVIOUR
//  Reset: cells all empty; RGB 0; hsync_out/vsync_out 1; blank_out 0; frame counter 0; blink_on 0.
//  Stage 1 (reg): dx=h_count-X0, dy=v_count-Y0 (17-bit signed); col=dx>>CELL_LOG2, row=dy>>CELL_LOG2;
//    lx,ly = low CELL_LOG2 bits; in_board = 0<=col<COLS && 0<=row<ROWS; in_cursor = row==-1 && col==cursor_col.
//  Stage 2 (reg): ox=lx-2**(CELL_LOG2-1), oy likewise (signed); d2=ox*ox+oy*oy (13-bit unsigned);
//    in_circle = d2 < RADIUS_SQ. Colour priority:
//    blank(delayed)=0 -> 000000; in_board&!in_circle -> 0000FF; in_board&in_circle -> by cell:
//    empty FFFFFF, p1 FF0000, p2 FFFF00, highlight 00FF00; in_cursor&in_circle&blink_on -> p1/p2 colour
//    per cursor_player; everything else 000000.
//  Latency: RGB for pixel (h,v) valid exactly 2 clk after h_count=h,v_count=v; sync/blank delayed equally.
//  Cell writes: take effect next cycle; stage-2 read in same cycle as write sees old value.
//    wr_col>=COLS or wr_row>=ROWS ignored. clear has priority over wr_en in same cycle; takes 1 cycle.
//  Frame tick: one-cycle pulse when h_count==0 && v_count==480. Counter counts ticks 0..BLINK_FRAMES-1;
//    on tick at BLINK_FRAMES-1 wraps to 0 and blink_on toggles.
//  cursor_col/cursor_player sampled in stage 1; changes apply to next pixel, no tearing protection.
//  rst_n asserted mid-frame: all state cleared immediately; output resumes on next pixel after release
//    (first 2 cycles output reset values).
// TESTING
//  Reset, then drive pixel (96,64) with blank_in=1 -> 2 cycles later RGB=0000FF (corner outside circle).
//  Write col0,row0=1; pixel (128,96) -> FF0000 at +2 cycles; same pixel with cell empty -> FFFFFF.
//  wr_en with wr_col=7 (COLS=7) -> no cell changes; clear+wr_en same cycle -> all cells empty.
//  Run 30 frame ticks, cursor_col=3, pixel (320,32) -> 000000 before 30th tick, FF0000/FFFF00 after.
//  Toggle hsync_in/vsync_in/blank_in -> outputs match input delayed exactly 2 cycles; blank_in=0 forces RGB 0.
//  Assert rst_n low mid-line -> RGB 0, syncs 1, cells empty, blink_on 0 same edge.

Source files
------------

// File: rtl/vga_board_renderer.sv
`default_nettype none
// ============================================================================
// Module   : vga_board_renderer
// Purpose  : Two-stage pixel pipeline that draws a COLS x ROWS board of round
//            cells and a blinking cursor piece above the selected column.
//            Syncs and blank are delayed two cycles to match the colour.
// Revision : 1.0 - initial release
// ============================================================================
module vga_board_renderer #(
    parameter int COLS         = 7,
    parameter int ROWS         = 6,
    parameter int CELL_LOG2    = 6,
    parameter int X0           = 96,
    parameter int Y0           = 64,
    parameter int RADIUS_SQ    = 676,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] h_count,
    input  logic [15:0] v_count,
    input  logic        blank_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        wr_en,
    input  logic [2:0]  wr_col,
    input  logic [2:0]  wr_row,
    input  logic [1:0]  wr_data,
    input  logic        clear,
    input  logic [2:0]  cursor_col,
    input  logic        cursor_player,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out
);

    localparam int CELL = 1 << CELL_LOG2;
    localparam int HALF = CELL / 2;
    localparam int OW   = CELL_LOG2 + 1;
    localparam int SW   = 2 * OW;
    localparam int CW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [23:0] C_BLACK  = 24'h000000;
    localparam logic [23:0] C_BLUE   = 24'h0000FF;
    localparam logic [23:0] C_WHITE  = 24'hFFFFFF;
    localparam logic [23:0] C_RED    = 24'hFF0000;
    localparam logic [23:0] C_YELLOW = 24'hFFFF00;
    localparam logic [23:0] C_GREEN  = 24'h00FF00;

    // ------------------------------------------------------------------
    // Stage 1 address decode (combinational part)
    // ------------------------------------------------------------------
    logic signed [16:0] dx_w, dy_w, col_w, row_w;
    logic               in_board_w, in_cursor_w;

    assign dx_w  = $signed({1'b0, h_count}) - $signed(17'(X0));
    assign dy_w  = $signed({1'b0, v_count}) - $signed(17'(Y0));
    // Arithmetic shift floors negative offsets so the band above the board is row -1.
    assign col_w = dx_w >>> CELL_LOG2;
    assign row_w = dy_w >>> CELL_LOG2;

    assign in_board_w  = (col_w >= 17'sd0) && (col_w < $signed(17'(COLS))) &&
                         (row_w >= 17'sd0) && (row_w < $signed(17'(ROWS)));
    assign in_cursor_w = (row_w == -17'sd1) && (col_w == $signed({14'd0, cursor_col}));

    logic                 in_board_q, in_cursor_q, player_q;
    logic [2:0]           col_q, row_q;
    logic [CELL_LOG2-1:0] lx_q, ly_q;
    logic                 blank1_q, hs1_q, vs1_q;

    // Stage 1 registers: cell coordinates, in-cell offsets and delayed controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_board_q  <= 1'b0;
            in_cursor_q <= 1'b0;
            player_q    <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            lx_q        <= '0;
            ly_q        <= '0;
            blank1_q    <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
        end else begin
            in_board_q  <= in_board_w;
            in_cursor_q <= in_cursor_w;
            player_q    <= cursor_player;
            col_q       <= col_w[2:0];
            row_q       <= row_w[2:0];
            lx_q        <= dx_w[CELL_LOG2-1:0];
            ly_q        <= dy_w[CELL_LOG2-1:0];
            blank1_q    <= blank_in;
            hs1_q       <= hsync_in;
            vs1_q       <= vsync_in;
        end
    end

    // ------------------------------------------------------------------
    // Cell state register file, indexed by {row, col}
    // ------------------------------------------------------------------
    logic [1:0] cells_q [64];
    logic       wr_ok_w;

    assign wr_ok_w = (32'(wr_col) < 32'(COLS)) && (32'(wr_row) < 32'(ROWS));

    // Cell writes; clear wins over a simultaneous single-cell write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) cells_q[i] <= 2'd0;
        end else if (clear) begin
            for (int i = 0; i < 64; i++) cells_q[i] <= 2'd0;
        end else if (wr_en && wr_ok_w) begin
            cells_q[{wr_row, wr_col}] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Frame counter and cursor blink
    // ------------------------------------------------------------------
    logic          tick_w;
    logic [CW-1:0] frame_q;
    logic          blink_q;

    assign tick_w = (h_count == 16'd0) && (v_count == 16'd480);

    // Count frame ticks; toggle the cursor blink every BLINK_FRAMES ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
            blink_q <= 1'b0;
        end else if (tick_w) begin
            if (frame_q == CW'(BLINK_FRAMES - 1)) begin
                frame_q <= '0;
                blink_q <= ~blink_q;
            end else begin
                frame_q <= frame_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: circle test and colour selection
    // ------------------------------------------------------------------
    logic signed [OW-1:0] ox_w, oy_w;
    logic signed [SW-1:0] oxe_w, oye_w, sqx_w, sqy_w;
    logic [SW-1:0]        d2_w;
    logic                 in_circle_w;
    logic [1:0]           cell_w;
    logic [23:0]          rgb_d;

    assign ox_w  = $signed({1'b0, lx_q}) - $signed(OW'(HALF));
    assign oy_w  = $signed({1'b0, ly_q}) - $signed(OW'(HALF));
    assign oxe_w = SW'(ox_w);
    assign oye_w = SW'(oy_w);
    assign sqx_w = oxe_w * oxe_w;
    assign sqy_w = oye_w * oye_w;
    assign d2_w  = $unsigned(sqx_w) + $unsigned(sqy_w);
    assign in_circle_w = d2_w < SW'(RADIUS_SQ);
    assign cell_w      = cells_q[{row_q, col_q}];

    // Colour priority: blanking, board frame, board piece, cursor piece.
    always_comb begin
        rgb_d = C_BLACK;
        if (!blank1_q) begin
            rgb_d = C_BLACK;
        end else if (in_board_q) begin
            if (!in_circle_w) begin
                rgb_d = C_BLUE;
            end else begin
                case (cell_w)
                    2'd0:    rgb_d = C_WHITE;
                    2'd1:    rgb_d = C_RED;
                    2'd2:    rgb_d = C_YELLOW;
                    default: rgb_d = C_GREEN;
                endcase
            end
        end else if (in_cursor_q && in_circle_w && blink_q) begin
            rgb_d = player_q ? C_YELLOW : C_RED;
        end
    end

    logic [23:0] rgb_q;
    logic        blank2_q, hs2_q, vs2_q;

    // Stage 2 registers: final colour and the second sync/blank delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q    <= '0;
            blank2_q <= 1'b0;
            hs2_q    <= 1'b1;
            vs2_q    <= 1'b1;
        end else begin
            rgb_q    <= rgb_d;
            blank2_q <= blank1_q;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
        end
    end

    assign red       = rgb_q[23:16];
    assign green     = rgb_q[15:8];
    assign blue      = rgb_q[7:0];
    assign hsync_out = hs2_q;
    assign vsync_out = vs2_q;
    assign blank_out = blank2_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_board_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_board_renderer
// Purpose  : Self-checking bench; a geometric reference model predicts every
//            output pixel two cycles ahead, plus hand-computed spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_board_renderer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] h_count, v_count;
    logic        blank_in, hsync_in, vsync_in;
    logic        wr_en, clear, cursor_player;
    logic [2:0]  wr_col, wr_row, cursor_col;
    logic [1:0]  wr_data;
    logic [7:0]  red, green, blue;
    logic        hsync_out, vsync_out, blank_out;

    vga_board_renderer dut (
        .clk(clk), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
        .blank_in(blank_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data),
        .clear(clear), .cursor_col(cursor_col), .cursor_player(cursor_player),
        .red(red), .green(green), .blue(blue),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out)
    );

    always #5 clk = ~clk;

    localparam logic [26:0] RST_EXP = {24'h000000, 1'b1, 1'b1, 1'b0};

    int          n_vec = 0;
    int          n_bad = 0;
    logic        chk_en = 1'b0;
    logic [26:0] exp_mid = RST_EXP;
    logic [26:0] exp_out = RST_EXP;

    // Reference model state
    int   m_cells [0:5][0:6];
    int   m_cnt   = 0;
    logic m_blink = 1'b0;

    function automatic int floor64(input int a);
        return (a >= 0) ? a / 64 : -((-a + 63) / 64);
    endfunction

    // Colour of a pixel from board geometry and current model state.
    function automatic logic [23:0] model_rgb(input int h, input int v, input logic bl,
                                             input int ccol, input logic cply);
        int dx, dy, col, row, lx, ly, d2;
        if (!bl) return 24'h000000;
        dx  = h - 96;
        dy  = v - 64;
        col = floor64(dx);
        row = floor64(dy);
        lx  = dx - col * 64;
        ly  = dy - row * 64;
        d2  = (lx - 32) * (lx - 32) + (ly - 32) * (ly - 32);
        if (col >= 0 && col < 7 && row >= 0 && row < 6) begin
            if (d2 >= 676) return 24'h0000FF;
            case (m_cells[row][col])
                0:       return 24'hFFFFFF;
                1:       return 24'hFF0000;
                2:       return 24'hFFFF00;
                default: return 24'h00FF00;
            endcase
        end
        if (row == -1 && col == ccol && d2 < 676 && m_blink)
            return cply ? 24'hFFFF00 : 24'hFF0000;
        return 24'h000000;
    endfunction

    task automatic m_clear();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++) m_cells[r][c] = 0;
    endtask

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Per-cycle comparison of every output against the model's prediction.
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if ({red, green, blue, hsync_out, vsync_out, blank_out} !== exp_out) begin
                n_bad++;
                $display("FAIL pipe t=%0t actual rgb=%h hs=%b vs=%b bl=%b required rgb=%h hs=%b vs=%b bl=%b",
                         $time, {red, green, blue}, hsync_out, vsync_out, blank_out,
                         exp_out[26:3], exp_out[2], exp_out[1], exp_out[0]);
            end
        end
    end

    // Apply the current inputs for one clock and predict the result 2 cycles later.
    task automatic cycle();
        logic [26:0] e;
        if (rst_n) begin
            if (clear) m_clear();
            else if (wr_en && wr_col < 7 && wr_row < 6) m_cells[wr_row][wr_col] = int'(wr_data);
            if (h_count == 16'd0 && v_count == 16'd480) begin
                if (m_cnt == 29) begin
                    m_cnt   = 0;
                    m_blink = ~m_blink;
                end else begin
                    m_cnt++;
                end
            end
            e = {model_rgb(int'(h_count), int'(v_count), blank_in, int'(cursor_col), cursor_player),
                 hsync_in, vsync_in, blank_in};
        end else begin
            e = RST_EXP;
        end
        @(posedge clk);
        exp_out = exp_mid;
        exp_mid = e;
        if (!rst_n) begin
            exp_out = RST_EXP;
            exp_mid = RST_EXP;
        end
        @(negedge clk);
    endtask

    task automatic set_pix(input int h, input int v, input logic bl);
        h_count  = 16'(h);
        v_count  = 16'(v);
        blank_in = bl;
        wr_en    = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic idle();
        set_pix(799, 10, 1'b0);
    endtask

    // Show a pixel, then report its colour two clocks later.
    task automatic probe(input string name, input int h, input int v, input logic [23:0] req);
        set_pix(h, v, 1'b1);
        cycle();
        idle();
        cycle();
        check(name, {red, green, blue}, req);
    endtask

    task automatic write_cell(input int c, input int r, input int d, input logic clr);
        idle();
        wr_en   = 1'b1;
        wr_col  = 3'(c);
        wr_row  = 3'(r);
        wr_data = 2'(d);
        clear   = clr;
        cycle();
        wr_en = 1'b0;
        clear = 1'b0;
    endtask

    task automatic tick();
        set_pix(0, 480, 1'b0);
        cycle();
    endtask

    initial begin
        m_clear();
        rst_n = 1'b0;
        idle();
        hsync_in = 1'b1; vsync_in = 1'b1;
        wr_col = 3'd0; wr_row = 3'd0; wr_data = 2'd0;
        cursor_col = 3'd3; cursor_player = 1'b0;
        repeat (3) cycle();
        check("reset_rgb", {red, green, blue}, 24'h000000);
        check("reset_syncs", {21'd0, hsync_out, vsync_out, blank_out}, {21'd0, 3'b110});
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Hand-computed pins on the model itself
        check("model_corner", model_rgb(96, 64, 1'b1, 3, 1'b0), 24'h0000FF);
        check("model_center_empty", model_rgb(128, 96, 1'b1, 3, 1'b0), 24'hFFFFFF);
        check("model_outside", model_rgb(600, 300, 1'b1, 3, 1'b0), 24'h000000);

        // Directed board drawing
        probe("corner_blue", 96, 64, 24'h0000FF);
        write_cell(0, 0, 1, 1'b0);
        probe("cell00_p1", 128, 96, 24'hFF0000);
        write_cell(0, 0, 0, 1'b0);
        probe("cell00_empty", 128, 96, 24'hFFFFFF);
        write_cell(7, 0, 2, 1'b0);
        write_cell(0, 6, 2, 1'b0);
        probe("col6_untouched", 512, 96, 24'hFFFFFF);
        probe("cell00_untouched", 128, 96, 24'hFFFFFF);
        write_cell(2, 3, 2, 1'b0);
        write_cell(5, 5, 3, 1'b0);
        probe("cell23_p2", 256, 288, 24'hFFFF00);
        probe("cell55_hl", 448, 416, 24'h00FF00);
        write_cell(1, 1, 1, 1'b1);
        probe("clear_23", 256, 288, 24'hFFFFFF);
        probe("clear_55", 448, 416, 24'hFFFFFF);
        probe("clear_11", 192, 160, 24'hFFFFFF);
        set_pix(128, 96, 1'b0);
        cycle(); idle(); cycle();
        check("blank_forces_black", {red, green, blue}, 24'h000000);

        // Cursor blink
        cursor_col = 3'd3; cursor_player = 1'b0;
        probe("cursor_off", 320, 32, 24'h000000);
        repeat (29) tick();
        probe("cursor_29_ticks", 320, 32, 24'h000000);
        tick();
        probe("cursor_on_p1", 320, 32, 24'hFF0000);
        cursor_player = 1'b1;
        probe("cursor_on_p2", 320, 32, 24'hFFFF00);
        cursor_col = 3'd4;
        probe("cursor_other_col", 320, 32, 24'h000000);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(19) == 0) begin
                h_count = 16'd0; v_count = 16'd480;
            end else if ($urandom_range(1) == 0) begin
                h_count = 16'($urandom_range(560, 60));
                v_count = 16'($urandom_range(470, 0));
            end else begin
                h_count = 16'($urandom_range(799));
                v_count = 16'($urandom_range(524));
            end
            blank_in      = ($urandom_range(6) != 0);
            hsync_in      = 1'($urandom);
            vsync_in      = 1'($urandom);
            wr_en         = ($urandom_range(9) < 3);
            wr_col        = 3'($urandom);
            wr_row        = 3'($urandom);
            wr_data       = 2'($urandom);
            clear         = ($urandom_range(49) == 0);
            cursor_col    = 3'($urandom);
            cursor_player = 1'($urandom);
            cycle();
        end

        // Mid-line asynchronous reset
        write_cell(0, 0, 2, 1'b0);
        probe("pre_reset_cell", 128, 96, 24'hFFFF00);
        set_pix(100, 70, 1'b1);
        hsync_in = 1'b0; vsync_in = 1'b0;
        cycle(); cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rgb", {red, green, blue}, 24'h000000);
        check("async_syncs", {21'd0, hsync_out, vsync_out, blank_out}, {21'd0, 3'b110});
        m_clear();
        m_cnt   = 0;
        m_blink = 1'b0;
        exp_out = RST_EXP;
        exp_mid = RST_EXP;
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        hsync_in = 1'b1; vsync_in = 1'b1;
        probe("post_reset_cell", 128, 96, 24'hFFFFFF);
        cursor_col = 3'd3;
        probe("post_reset_blink", 320, 32, 24'h000000);
        idle();
        cycle(); cycle();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
